ram_access_ctrl: RTL and testbench
==================================

# ram_access_ctrl

Clocked controller that shares the single asynchronous `ram512x8` data memory between the instruction-fetch port and the load/store data port. It arbitrates, checks size/alignment, and drives the RAM's level-sensitive `enable`/`readWrite`/`MAS`/`address`/`dataIn` pins for a fixed minimum window. It captures `dataOut` on `done` and returns one response pulse per accepted request. It sits between the CPU memory stage/fetch unit and the RAM.

## Interface
- `ADDR_W`, 9, RAM byte-address width.
- `DATA_W`, 32, data width.
- `SETUP_CYCLES`, 2, minimum cycles `ram_enable` is held per access (≥1).
- `TIMEOUT`, 15, maximum ACCESS cycles before a timeout fault (> `SETUP_CYCLES`).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch byte address; always a word read.
- `if_gnt`  out  1  one-cycle accept pulse.
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` valid.
- `if_fault`  out  1  one-cycle error-response pulse.
- `if_rdata`  out  DATA_W  fetched word.
- `dp_req`  in  1  data request; held until `dp_gnt`.
- `dp_we`  in  1  1 = write, 0 = read.
- `dp_mas`  in  2  size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `dp_addr`  in  ADDR_W  byte address.
- `dp_wdata`  in  DATA_W  write data, right-justified.
- `dp_gnt`, `dp_rvalid`, `dp_fault`  out  1 each  as the fetch port.
- `dp_rdata`  out  DATA_W  read data, zero-extended.
- `ram_enable`  out  1  RAM enable.
- `ram_read_write`  out  1  1 = read, 0 = write.
- `ram_mas`  out  2  RAM size.
- `ram_address`  out  ADDR_W  RAM address.
- `ram_data_in`  out  DATA_W  RAM write data.
- `ram_data_out`  in  DATA_W  RAM read data (Z when disabled).
- `ram_done`  in  1  RAM completion.

## Operation
- Request semantics:
  - Request fields are sampled in the cycle `*_gnt` is high.
  - Dropping `req` before grant is illegal.
  - Holding `req` after grant means a new request.
- Arbitration (IDLE only): single requester wins. If both request, the port not served last wins (round-robin); `last` resets to fetch, so data wins the first tie.
- Legality, checked at grant:
  - MAS = 11 is a fault.
  - Half access with `addr[0]` = 1 is a fault.
  - Word access with `addr[1:0]` ≠ 0 is a fault.
  - Any access with addr + size − 1 > 511 is a fault.
  - A faulting request never asserts `ram_enable`.
- FSM states:
  - IDLE: `ram_enable` = 0. On a winner, pulse gnt, latch fields into `ram_*` registers and the requester id. Go to FAULT if illegal, else ACCESS.
  - ACCESS: `ram_enable` = 1, cycle counter increments from 0.
    - Exit when counter ≥ SETUP_CYCLES−1 and `ram_done` = 1. On a read, register `ram_data_out` (bits above the MAS size forced to 0) into the owner's rdata. Go to RESP.
    - If counter reaches TIMEOUT−1 without exit, set the fault flag and go to RESP.
  - RESP: `ram_enable` = 0 (mandatory recovery cycle so the RAM re-evaluates). Pulse the owner's rvalid, or fault if the flag is set. Go to IDLE.
  - FAULT: pulse the owner's fault. Go to IDLE.
- Writes: rvalid acts as the write acknowledge; rdata is unchanged.
- Fetch port: always `ram_mas` = 10, `ram_read_write` = 1.
- `ram_address`, `ram_mas`, `ram_read_write`, `ram_data_in` are stable for the whole ACCESS window.

## Timing
- Grant at cycle T.
- `ram_enable` high T+1 … T+SETUP_CYCLES.
- rvalid at T+SETUP_CYCLES+1 (T+3 by default).
- Next grant no earlier than T+SETUP_CYCLES+2, giving peak throughput of one access per SETUP_CYCLES+2 cycles.
- A fault response arrives at T+1.
- A timeout response arrives at T+TIMEOUT+1.
- Exactly one response per grant; the gnt→response interval of one access never overlaps another's.
- Reset values:
  - All `*_gnt`, `*_rvalid`, `*_fault`, and `ram_enable` are 0.
  - `ram_read_write` = 1, `ram_mas` = 10.
  - `ram_address`, `ram_data_in`, `if_rdata`, `dp_rdata` are 0.
  - State = IDLE, `last` = fetch.
- Reset mid-access: `ram_enable` drops asynchronously and no response is issued. A partially performed write leaves those RAM bytes undefined.

## Structure
- Shared package holds:
  - MAS constants `MAS_BYTE`/`MAS_HALF`/`MAS_WORD`.
  - State enum IDLE/ACCESS/RESP/FAULT.
  - Requester-id constants `REQ_IF`/`REQ_DP`.
- One sub-module: `ram_rr_arbiter`, a two-input round-robin arbiter with its `last` register, enabled only in IDLE.
- Legality check and rdata masking are combinational in the top level.

## Test plan
- `dp` write word 0xDEADBEEF @0x010, then `dp` read word @0x010: rvalid at T+3, `dp_rdata` = 0xDEADBEEF. Byte read @0x011 returns 0x000000AD.
- `if_req` and `dp_req` high together from reset: grants go `dp`, then `if`, then `dp`. `ram_enable` is low for ≥1 cycle between accesses.
- `dp` half read @0x013, word @0x1FE, MAS = 11: `dp_fault` at T+1, `ram_enable` never rises.
- `ram_done` tied 0: `dp_fault` at T+16, FSM back in IDLE, next request served normally.
- `rst_n` low during ACCESS: `ram_enable` drops without a clock edge, no response pulses, all outputs equal their reset values.
- Back-to-back `if_req` held high: a grant every 4 cycles, each followed by exactly one `if_rvalid`.

Source files
------------

// File: rtl/ram_access_ctrl_pkg.sv
// rtl/ram_access_ctrl_pkg.sv - shared constants and types for the RAM access controller
package ram_access_ctrl_pkg;

    localparam logic [1:0] MAS_BYTE = 2'b00;
    localparam logic [1:0] MAS_HALF = 2'b01;
    localparam logic [1:0] MAS_WORD = 2'b10;
    localparam logic [1:0] MAS_ILL  = 2'b11;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DP = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10,
        FAULT  = 2'b11
    } state_t;

endpackage

// File: rtl/ram_rr_arbiter.sv
// rtl/ram_rr_arbiter.sv - two-input round-robin arbiter between fetch and data ports
module ram_rr_arbiter
    import ram_access_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_if,
    input  logic req_dp,
    output logic gnt_if,
    output logic gnt_dp
);

    logic last;

    // Grant the lone requester; on a tie grant the port that was not served last.
    always_comb begin
        gnt_if = 1'b0;
        gnt_dp = 1'b0;
        if (en) begin
            if (req_if && req_dp) begin
                if (last == REQ_IF) gnt_dp = 1'b1;
                else                gnt_if = 1'b1;
            end else begin
                gnt_if = req_if;
                gnt_dp = req_dp;
            end
        end
    end

    // Remember which port was served most recently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last <= REQ_IF;
        else if (gnt_dp) last <= REQ_DP;
        else if (gnt_if) last <= REQ_IF;
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - arbitrated, size-checked access controller for the shared ram512x8
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 32,
    parameter int SETUP_CYCLES = 2,
    parameter int TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic              if_fault,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dp_req,
    input  logic              dp_we,
    input  logic [1:0]        dp_mas,
    input  logic [ADDR_W-1:0] dp_addr,
    input  logic [DATA_W-1:0] dp_wdata,
    output logic              dp_gnt,
    output logic              dp_rvalid,
    output logic              dp_fault,
    output logic [DATA_W-1:0] dp_rdata,
    output logic              ram_enable,
    output logic              ram_read_write,
    output logic [1:0]        ram_mas,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    input  logic              ram_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              owner;
    logic              timed_out;
    logic              any_gnt;
    logic              access_done;
    logic              sel_we;
    logic [1:0]        sel_mas;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W:0]   size_m1;
    logic [ADDR_W:0]   end_addr;
    logic              illegal;
    logic [DATA_W-1:0] rdata_masked;

    ram_rr_arbiter u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state == IDLE),
        .req_if (if_req),
        .req_dp (dp_req),
        .gnt_if (if_gnt),
        .gnt_dp (dp_gnt)
    );

    assign any_gnt     = if_gnt | dp_gnt;
    assign access_done = (cnt >= SETUP_LAST) && ram_done;

    // Select the winning request's fields; fetches are always word reads.
    always_comb begin
        sel_we    = 1'b0;
        sel_mas   = MAS_WORD;
        sel_addr  = if_addr;
        sel_wdata = '0;
        if (dp_gnt) begin
            sel_we    = dp_we;
            sel_mas   = dp_mas;
            sel_addr  = dp_addr;
            sel_wdata = dp_wdata;
        end
    end

    // Legality: size code, natural alignment, and last byte inside the RAM.
    always_comb begin
        size_m1 = '0;
        case (sel_mas)
            MAS_HALF: size_m1 = (ADDR_W+1)'(1);
            MAS_WORD: size_m1 = (ADDR_W+1)'(3);
            default:  size_m1 = '0;
        endcase
        end_addr = {1'b0, sel_addr} + size_m1;
        illegal  = (sel_mas == MAS_ILL)
                 | ((sel_mas == MAS_HALF) && sel_addr[0])
                 | ((sel_mas == MAS_WORD) && (sel_addr[1:0] != 2'b00))
                 | end_addr[ADDR_W];
    end

    // Zero the bytes above the access size so reads come back zero-extended.
    always_comb begin
        rdata_masked = ram_data_out;
        case (ram_mas)
            MAS_BYTE: rdata_masked = {{(DATA_W-8){1'b0}},  ram_data_out[7:0]};
            MAS_HALF: rdata_masked = {{(DATA_W-16){1'b0}}, ram_data_out[15:0]};
            default:  rdata_masked = ram_data_out;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and response/enable decode.
    always_comb begin
        state_next = state;
        ram_enable = 1'b0;
        if_rvalid  = 1'b0;
        dp_rvalid  = 1'b0;
        if_fault   = 1'b0;
        dp_fault   = 1'b0;
        case (state)
            IDLE: begin
                if (any_gnt) state_next = illegal ? FAULT : ACCESS;
            end
            ACCESS: begin
                ram_enable = 1'b1;
                if (access_done || (cnt == TO_LAST)) state_next = RESP;
            end
            RESP: begin
                if_rvalid  = !timed_out && (owner == REQ_IF);
                dp_rvalid  = !timed_out && (owner == REQ_DP);
                if_fault   = timed_out && (owner == REQ_IF);
                dp_fault   = timed_out && (owner == REQ_DP);
                state_next = IDLE;
            end
            FAULT: begin
                if_fault   = (owner == REQ_IF);
                dp_fault   = (owner == REQ_DP);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the granted request, run the access counter, capture read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_read_write <= 1'b1;
            ram_mas        <= MAS_WORD;
            ram_address    <= '0;
            ram_data_in    <= '0;
            owner          <= REQ_IF;
            timed_out      <= 1'b0;
            cnt            <= '0;
            if_rdata       <= '0;
            dp_rdata       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_gnt) begin
                        ram_read_write <= !sel_we;
                        ram_mas        <= sel_mas;
                        ram_address    <= sel_addr;
                        ram_data_in    <= sel_wdata;
                        owner          <= dp_gnt ? REQ_DP : REQ_IF;
                        timed_out      <= 1'b0;
                        cnt            <= '0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (access_done) begin
                        if (ram_read_write) begin
                            if (owner == REQ_DP) dp_rdata <= rdata_masked;
                            else                 if_rdata <= rdata_masked;
                        end
                    end else if (cnt == TO_LAST) begin
                        timed_out <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - directed self-checking bench for ram_access_ctrl
module tb_ram_access_ctrl;
    import ram_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [8:0]  if_addr = '0;
    logic        if_gnt, if_rvalid, if_fault;
    logic [31:0] if_rdata;
    logic        dp_req = 1'b0;
    logic        dp_we = 1'b0;
    logic [1:0]  dp_mas = 2'b10;
    logic [8:0]  dp_addr = '0;
    logic [31:0] dp_wdata = '0;
    logic        dp_gnt, dp_rvalid, dp_fault;
    logic [31:0] dp_rdata;
    logic        ram_enable, ram_read_write;
    logic [1:0]  ram_mas;
    logic [8:0]  ram_address;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out;
    logic        ram_done;
    logic        done_en = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [0:511];
    int ra;

    ram_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_fault(if_fault), .if_rdata(if_rdata),
        .dp_req(dp_req), .dp_we(dp_we), .dp_mas(dp_mas), .dp_addr(dp_addr),
        .dp_wdata(dp_wdata), .dp_gnt(dp_gnt), .dp_rvalid(dp_rvalid), .dp_fault(dp_fault),
        .dp_rdata(dp_rdata),
        .ram_enable(ram_enable), .ram_read_write(ram_read_write), .ram_mas(ram_mas),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .ram_done(ram_done)
    );

    always #5 clk = ~clk;

    // Big-endian byte RAM; upper bits of narrow reads carry junk the DUT must clear.
    always_comb begin
        ra = int'(ram_address);
        ram_data_out = '0;
        if (ram_enable && ram_read_write) begin
            case (ram_mas)
                MAS_BYTE: ram_data_out = {24'hFFFFFF, mem[ra]};
                MAS_HALF: ram_data_out = {16'hFFFF, mem[ra], mem[(ra+1)%512]};
                default:  ram_data_out = {mem[ra], mem[(ra+1)%512], mem[(ra+2)%512], mem[(ra+3)%512]};
            endcase
        end
    end

    assign ram_done = ram_enable & done_en;

    always @(posedge clk) begin
        if (ram_enable && !ram_read_write) begin
            case (ram_mas)
                MAS_BYTE: mem[ra] <= ram_data_in[7:0];
                MAS_HALF: begin
                    mem[ra]         <= ram_data_in[15:8];
                    mem[(ra+1)%512] <= ram_data_in[7:0];
                end
                default: begin
                    mem[ra]         <= ram_data_in[31:24];
                    mem[(ra+1)%512] <= ram_data_in[23:16];
                    mem[(ra+2)%512] <= ram_data_in[15:8];
                    mem[(ra+3)%512] <= ram_data_in[7:0];
                end
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = no response, 1 = rvalid, 2 = fault, 3 = never granted; lat counted from grant cycle.
    task automatic dp_issue(input logic we, input logic [1:0] mas, input logic [8:0] addr,
                            input logic [31:0] wdata, output int lat, output int kind,
                            output int en_cyc, output logic [31:0] rdata);
        bit got;
        got = 0; lat = -1; kind = 0; en_cyc = 0; rdata = '0;
        dp_we = we; dp_mas = mas; dp_addr = addr; dp_wdata = wdata; dp_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (dp_gnt) begin got = 1; break; end
            @(posedge clk); #1;
        end
        if (!got) begin
            dp_req = 1'b0;
            kind = 3;
            tick;
            return;
        end
        tick;
        dp_req = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (ram_enable) en_cyc++;
            if (dp_rvalid || dp_fault) begin
                lat = c;
                kind = dp_rvalid ? 1 : 2;
                rdata = dp_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick; tick;
        n_cmp++;
        if ({if_gnt, dp_gnt, if_rvalid, dp_rvalid, if_fault, dp_fault, ram_enable} !== 7'b0) begin
            n_bad++; $display("FAIL reset_pulses: got %b expected 0000000",
                {if_gnt, dp_gnt, if_rvalid, dp_rvalid, if_fault, dp_fault, ram_enable});
        end
        n_cmp++;
        if ({ram_read_write, ram_mas} !== 3'b110) begin
            n_bad++; $display("FAIL reset_rw_mas: got %b expected 110", {ram_read_write, ram_mas});
        end
        n_cmp++;
        if ({ram_address, ram_data_in, if_rdata, dp_rdata} !== 105'b0) begin
            n_bad++; $display("FAIL reset_data: got addr %h din %h ifr %h dpr %h expected all 0",
                ram_address, ram_data_in, if_rdata, dp_rdata);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_write_read;
        int lat, kind, en;
        logic [31:0] rd;
        dp_issue(1'b1, MAS_WORD, 9'h010, 32'hDEADBEEF, lat, kind, en, rd);
        n_cmp++;
        if (kind !== 1 || lat !== 3 || en !== 2) begin
            n_bad++; $display("FAIL wr_word: got kind %0d lat %0d en %0d expected 1 3 2", kind, lat, en);
        end
        dp_issue(1'b0, MAS_WORD, 9'h010, 32'h0, lat, kind, en, rd);
        n_cmp++;
        if (kind !== 1 || lat !== 3 || en !== 2) begin
            n_bad++; $display("FAIL rd_word_timing: got kind %0d lat %0d en %0d expected 1 3 2", kind, lat, en);
        end
        n_cmp++;
        if (rd !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL rd_word_data: got %h expected deadbeef", rd);
        end
        dp_issue(1'b0, MAS_BYTE, 9'h011, 32'h0, lat, kind, en, rd);
        n_cmp++;
        if (kind !== 1 || rd !== 32'h000000AD) begin
            n_bad++; $display("FAIL rd_byte: got kind %0d data %h expected 1 000000ad", kind, rd);
        end
        dp_issue(1'b0, MAS_HALF, 9'h012, 32'h0, lat, kind, en, rd);
        n_cmp++;
        if (kind !== 1 || rd !== 32'h0000BEEF) begin
            n_bad++; $display("FAIL rd_half: got kind %0d data %h expected 1 0000beef", kind, rd);
        end
        dp_issue(1'b1, MAS_BYTE, 9'h013, 32'h00000055, lat, kind, en, rd);
        n_cmp++;
        if (kind !== 1 || rd !== 32'h0000BEEF) begin
            n_bad++; $display("FAIL wr_byte: got kind %0d rdata %h expected 1 0000beef (unchanged)", kind, rd);
        end
        dp_issue(1'b0, MAS_WORD, 9'h010, 32'h0, lat, kind, en, rd);
        n_cmp++;
        if (rd !== 32'hDEADBE55) begin
            n_bad++; $display("FAIL rd_after_byte_wr: got %h expected deadbe55", rd);
        end
    endtask

    task automatic test_faults;
        int lat, kind, en;
        logic [31:0] rd;
        dp_issue(1'b0, MAS_HALF, 9'h013, 32'h0, lat, kind, en, rd);
        n_cmp++;
        if (kind !== 2 || lat !== 1 || en !== 0) begin
            n_bad++; $display("FAIL fault_half_odd: got kind %0d lat %0d en %0d expected 2 1 0", kind, lat, en);
        end
        dp_issue(1'b0, MAS_WORD, 9'h1FE, 32'h0, lat, kind, en, rd);
        n_cmp++;
        if (kind !== 2 || lat !== 1 || en !== 0) begin
            n_bad++; $display("FAIL fault_word_1fe: got kind %0d lat %0d en %0d expected 2 1 0", kind, lat, en);
        end
        dp_issue(1'b1, MAS_ILL, 9'h000, 32'h12345678, lat, kind, en, rd);
        n_cmp++;
        if (kind !== 2 || lat !== 1 || en !== 0) begin
            n_bad++; $display("FAIL fault_mas11: got kind %0d lat %0d en %0d expected 2 1 0", kind, lat, en);
        end
        dp_issue(1'b0, MAS_BYTE, 9'h1FF, 32'h0, lat, kind, en, rd);
        n_cmp++;
        if (kind !== 1 || lat !== 3) begin
            n_bad++; $display("FAIL edge_byte_1ff: got kind %0d lat %0d expected 1 3", kind, lat);
        end
        dp_issue(1'b0, MAS_HALF, 9'h1FE, 32'h0, lat, kind, en, rd);
        n_cmp++;
        if (kind !== 1 || lat !== 3) begin
            n_bad++; $display("FAIL edge_half_1fe: got kind %0d lat %0d expected 1 3", kind, lat);
        end
        dp_issue(1'b0, MAS_WORD, 9'h1FC, 32'h0, lat, kind, en, rd);
        n_cmp++;
        if (kind !== 1 || lat !== 3) begin
            n_bad++; $display("FAIL edge_word_1fc: got kind %0d lat %0d expected 1 3", kind, lat);
        end
    endtask

    task automatic test_timeout;
        int lat, kind, en;
        logic [31:0] rd;
        done_en = 1'b0;
        dp_issue(1'b0, MAS_WORD, 9'h010, 32'h0, lat, kind, en, rd);
        n_cmp++;
        if (kind !== 2 || lat !== 16 || en !== 15) begin
            n_bad++; $display("FAIL timeout: got kind %0d lat %0d en %0d expected 2 16 15", kind, lat, en);
        end
        done_en = 1'b1;
        dp_issue(1'b0, MAS_WORD, 9'h010, 32'h0, lat, kind, en, rd);
        n_cmp++;
        if (kind !== 1 || lat !== 3 || rd !== 32'hDEADBE55) begin
            n_bad++; $display("FAIL after_timeout: got kind %0d lat %0d data %h expected 1 3 deadbe55", kind, lat, rd);
        end
    endtask

    task automatic test_arbitration;
        int ng, n_ifr, n_dpr, cyc [3];
        logic ord [3];
        bit en_bad, both;
        ng = 0; n_ifr = 0; n_dpr = 0; en_bad = 0; both = 0;
        cyc = '{-1, -1, -1};
        ord = '{1'b0, 1'b0, 1'b0};
        rst_n = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
        if_addr = 9'h010;
        dp_we = 1'b0; dp_mas = MAS_WORD; dp_addr = 9'h010;
        if_req = 1'b1; dp_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (if_gnt && dp_gnt) both = 1;
            if ((if_gnt || dp_gnt) && ng < 3) begin
                if (ram_enable) en_bad = 1;
                ord[ng] = dp_gnt;
                cyc[ng] = i;
                ng++;
            end
            if (if_rvalid) n_ifr++;
            if (dp_rvalid) n_dpr++;
            @(posedge clk); #1;
            if (ng == 3) begin if_req = 1'b0; dp_req = 1'b0; end
        end
        n_cmp++;
        if (ng !== 3 || ord[0] !== 1'b1 || ord[1] !== 1'b0 || ord[2] !== 1'b1) begin
            n_bad++; $display("FAIL arb_order: got n %0d dp-flags %b%b%b expected 3 101", ng, ord[0], ord[1], ord[2]);
        end
        n_cmp++;
        if (cyc[1] - cyc[0] !== 4 || cyc[2] - cyc[1] !== 4) begin
            n_bad++; $display("FAIL arb_spacing: got %0d %0d expected 4 4", cyc[1] - cyc[0], cyc[2] - cyc[1]);
        end
        n_cmp++;
        if (en_bad || both) begin
            n_bad++; $display("FAIL arb_gap: got enable-at-grant %0d double-grant %0d expected 0 0", en_bad, both);
        end
        n_cmp++;
        if (n_ifr !== 1 || n_dpr !== 2 || if_rdata !== 32'hDEADBE55) begin
            n_bad++; $display("FAIL arb_resp: got ifr %0d dpr %0d if_rdata %h expected 1 2 deadbe55", n_ifr, n_dpr, if_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int ng, nr, g [3], rv [4];
        ng = 0; nr = 0;
        g = '{-1, -1, -1};
        rv = '{-1, -1, -1, -1};
        if_addr = 9'h1FC;
        if_req = 1'b1;
        for (int i = 0; i < 24; i++) begin
            #1;
            if (if_gnt && ng < 3) begin g[ng] = i; ng++; end
            if (if_rvalid && nr < 4) begin rv[nr] = i; nr++; end
            @(posedge clk); #1;
            if (ng == 3) if_req = 1'b0;
        end
        n_cmp++;
        if (ng !== 3 || g[1] - g[0] !== 4 || g[2] - g[1] !== 4) begin
            n_bad++; $display("FAIL b2b_grants: got n %0d gaps %0d %0d expected 3 4 4", ng, g[1] - g[0], g[2] - g[1]);
        end
        n_cmp++;
        if (nr !== 3 || rv[0] !== g[0] + 3 || rv[1] !== g[1] + 3 || rv[2] !== g[2] + 3) begin
            n_bad++; $display("FAIL b2b_rvalid: got n %0d at %0d %0d %0d expected 3 at %0d %0d %0d",
                nr, rv[0], rv[1], rv[2], g[0] + 3, g[1] + 3, g[2] + 3);
        end
    endtask

    task automatic test_reset_mid_access;
        int pulses;
        bit got;
        got = 0; pulses = 0;
        dp_we = 1'b1; dp_mas = MAS_WORD; dp_addr = 9'h040; dp_wdata = 32'hCAFEF00D; dp_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (dp_gnt) begin got = 1; break; end
            @(posedge clk); #1;
        end
        tick;
        dp_req = 1'b0;
        #1;
        n_cmp++;
        if (!got || ram_enable !== 1'b1) begin
            n_bad++; $display("FAIL mid_pre: got granted %0d enable %b expected 1 1", got, ram_enable);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ram_enable !== 1'b0) begin
            n_bad++; $display("FAIL mid_async_enable: got %b expected 0", ram_enable);
        end
        n_cmp++;
        if ({ram_read_write, ram_mas, ram_address, ram_data_in, if_rdata, dp_rdata} !== {3'b110, 105'b0}) begin
            n_bad++; $display("FAIL mid_reset_values: got rw %b mas %b addr %h din %h ifr %h dpr %h expected 1 10 0 0 0 0",
                ram_read_write, ram_mas, ram_address, ram_data_in, if_rdata, dp_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (if_rvalid || dp_rvalid || if_fault || dp_fault || ram_enable) pulses++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (if_rvalid || dp_rvalid || if_fault || dp_fault || ram_enable) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++; $display("FAIL mid_no_response: got %0d active cycles expected 0", pulses);
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_faults;
        test_timeout;
        test_arbitration;
        test_back_to_back;
        test_reset_mid_access;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
